// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared constants, state encoding and channel-index width rule for tdm_demux
package tdm_demux_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  // Smallest index width that can address n channels (at least 1 bit)
  function automatic int cw_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_deser_shift.sv
// rtl/tdm_demux_deser_shift.sv - W-bit MSB-first shift register with bit counter and word-complete flag
module tdm_demux_deser_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         restart,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] word,
  output logic         word_done
);

  localparam int BW = $clog2(W) + 1;

  logic [W-1:0]  sr_q, sr_d;
  logic [BW-1:0] cnt_q, cnt_d;

  // The completed word includes the bit being sampled on this edge
  always_comb begin
    word      = {sr_q[W-2:0], din};
    word_done = shift_en && (cnt_q == BW'(W - 1));
  end

  // Next shift/count state: clear wins, restart begins a fresh word with din as its MSB
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (restart) begin
      sr_d  = {{(W-1){1'b0}}, din};
      cnt_d = BW'(1);
    end else if (shift_en) begin
      sr_d  = word;
      cnt_d = word_done ? '0 : cnt_q + BW'(1);
    end
  end

  // Register shift state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM link receiver: frame alignment, deserialization and atomic channel publish
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF,
  parameter int CW   = cw_for(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            din,
  input  logic            sync,
  output logic [N_CH*W-1:0] ch_data,
  output logic            frame_valid,
  output logic            sync_err,
  output logic            locked,
  output logic [CW-1:0]   ch_idx
);

  state_e              state_q, state_d;
  logic [CW-1:0]       ch_idx_q, ch_idx_d;
  logic                exp_sync_q, exp_sync_d;
  logic [W-1:0]        stage_q [N_CH];
  logic [W-1:0]        stage_d [N_CH];
  logic [N_CH*W-1:0]   ch_data_q, ch_data_d;
  logic                frame_valid_q, frame_valid_d;
  logic                sync_err_q, sync_err_d;

  logic                sh_clr, sh_restart, sh_shift;
  logic [W-1:0]        sh_word;
  logic                sh_done;

  tdm_demux_deser_shift #(.W(W)) u_deser (
    .clk       (clk),
    .rst       (rst),
    .clr       (sh_clr),
    .restart   (sh_restart),
    .shift_en  (sh_shift),
    .din       (din),
    .word      (sh_word),
    .word_done (sh_done)
  );

  // Frame alignment, channel sequencing, staging and publish decision
  always_comb begin
    state_d       = state_q;
    ch_idx_d      = ch_idx_q;
    exp_sync_d    = exp_sync_q;
    stage_d       = stage_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    sh_clr        = 1'b0;
    sh_restart    = 1'b0;
    sh_shift      = 1'b0;
    if (en) begin
      if (state_q == HUNT) begin
        if (sync) begin
          sh_restart = 1'b1;
          ch_idx_d   = '0;
          exp_sync_d = 1'b0;
          state_d    = RECV;
        end
      end else if (exp_sync_q && !sync) begin
        // Missing sync after a complete frame: lose lock and drop this bit
        sync_err_d = 1'b1;
        state_d    = HUNT;
        ch_idx_d   = '0;
        exp_sync_d = 1'b0;
        sh_clr     = 1'b1;
      end else if (sync) begin
        // Expected frame start, or an unexpected one that aborts the partial frame
        sync_err_d = !exp_sync_q;
        sh_restart = 1'b1;
        ch_idx_d   = '0;
        exp_sync_d = 1'b0;
      end else begin
        sh_shift = 1'b1;
        if (sh_done) begin
          for (int k = 0; k < N_CH; k++) begin
            if (ch_idx_q == CW'(k)) stage_d[k] = sh_word;
          end
          if (ch_idx_q == CW'(N_CH - 1)) begin
            for (int k = 0; k < N_CH; k++) begin
              ch_data_d[k*W +: W] = stage_d[k];
            end
            frame_valid_d = 1'b1;
            ch_idx_d      = '0;
            exp_sync_d    = 1'b1;
          end else begin
            ch_idx_d = ch_idx_q + CW'(1);
          end
        end
      end
    end
  end

  // FSM and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      ch_idx_q      <= '0;
      exp_sync_q    <= 1'b0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int k = 0; k < N_CH; k++) stage_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      ch_idx_q      <= ch_idx_d;
      exp_sync_q    <= exp_sync_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      stage_q       <= stage_d;
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == RECV);
  assign ch_idx      = ch_idx_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed self-checking bench for tdm_demux
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        din = 1'b0;
  logic        sync = 1'b0;
  logic [31:0] ch_data;
  logic        frame_valid;
  logic        sync_err;
  logic        locked;
  logic [1:0]  ch_idx;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  int both_cnt = 0;
  int nb = 0;
  bit gap_mode = 1'b0;

  always #5 clk = ~clk;

  tdm_demux #(.N_CH(4), .W(8), .CW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .sync        (sync),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked),
    .ch_idx      (ch_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic s, input logic r);
    @(negedge clk);
    en = e; din = d; sync = s; rst = r;
    @(posedge clk);
    #1;
    if (frame_valid) fv_cnt++;
    if (sync_err) se_cnt++;
    if (frame_valid && sync_err) both_cnt++;
  endtask

  task automatic idle_gap();
    for (int g = 0; g < 3; g++) step(1'b0, g[0], 1'b1, 1'b0);
  endtask

  task automatic send_bit(input logic d, input logic s);
    step(1'b1, d, s, 1'b0);
    nb++;
    if (gap_mode && (nb % 5 == 0)) idle_gap();
  endtask

  task automatic send_word(input logic [7:0] w, input logic first);
    for (int i = 7; i >= 0; i--) send_bit(w[i], first && (i == 7));
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send_word(a, 1'b1);
    send_word(b, 1'b0);
    send_word(c, 1'b0);
    send_word(d, 1'b0);
  endtask

  task automatic clear_counts();
    fv_cnt = 0; se_cnt = 0; both_cnt = 0; nb = 0;
  endtask

  initial begin
    logic [15:0] junk;
    logic [7:0]  w01;

    // Reset state
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_ch_data", ch_data, 32'h0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_se", sync_err, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_ch_idx", ch_idx, 2'd0);

    // Single frame, continuous enable
    clear_counts();
    send_word(8'hA5, 1'b1);
    chk("f1_locked", locked, 1'b1);
    chk("f1_idx_after_w0", ch_idx, 2'd1);
    send_word(8'h3C, 1'b0);
    send_word(8'hFF, 1'b0);
    w01 = 8'h01;
    for (int i = 7; i >= 1; i--) send_bit(w01[i], 1'b0);
    chk("f1_idx_last", ch_idx, 2'd3);
    chk("f1_no_early_publish", ch_data, 32'h0);
    chk("f1_no_early_fv", fv_cnt, 0);
    send_bit(w01[0], 1'b0);
    chk("f1_fv_after_last", frame_valid, 1'b1);
    chk("f1_ch_data", ch_data, 32'h01FF3CA5);
    chk("f1_idx_wrap", ch_idx, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("f1_fv_one_cycle", frame_valid, 1'b0);
    chk("f1_hold_ch_data", ch_data, 32'h01FF3CA5);
    chk("f1_no_se", se_cnt, 0);

    // Same frame with enable gaps (sync toggled high during gaps must be ignored)
    step(1'b1, 1'b0, 1'b0, 1'b1);
    clear_counts();
    gap_mode = 1'b1;
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
    gap_mode = 1'b0;
    chk("gap_fv_after_last", frame_valid, 1'b1);
    chk("gap_ch_data", ch_data, 32'h01FF3CA5);
    chk("gap_fv_cnt", fv_cnt, 1);
    chk("gap_no_se", se_cnt, 0);

    // Back-to-back frames
    step(1'b1, 1'b0, 1'b0, 1'b1);
    clear_counts();
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
    chk("b2b_first", ch_data, 32'h01FF3CA5);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44);
    chk("b2b_ch_data", ch_data, 32'h44332211);
    chk("b2b_fv_cnt", fv_cnt, 2);
    chk("b2b_no_se", se_cnt, 0);
    chk("b2b_locked", locked, 1'b1);

    // Good frame then missing sync on bit 33
    step(1'b1, 1'b0, 1'b0, 1'b1);
    clear_counts();
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
    send_bit(1'b1, 1'b0);
    chk("nosync_se", sync_err, 1'b1);
    chk("nosync_unlocked", locked, 1'b0);
    chk("nosync_hold", ch_data, 32'h01FF3CA5);
    junk = 16'hBEEF;
    for (int i = 15; i >= 0; i--) send_bit(junk[i], 1'b0);
    chk("hunt_se_once", se_cnt, 1);
    chk("hunt_still_unlocked", locked, 1'b0);
    chk("hunt_idx", ch_idx, 2'd0);
    chk("hunt_fv_cnt", fv_cnt, 1);
    chk("hunt_hold", ch_data, 32'h01FF3CA5);

    // Sync again at bit 10 of a frame, then a full frame
    clear_counts();
    junk = 16'hDEAD;
    send_bit(junk[15], 1'b1);
    chk("resync_locked", locked, 1'b1);
    for (int i = 14; i >= 7; i--) send_bit(junk[i], 1'b0);
    chk("midsync_pre_se", se_cnt, 0);
    send_word(8'h0F, 1'b1);
    send_word(8'hF0, 1'b0);
    send_word(8'hAA, 1'b0);
    send_word(8'h55, 1'b0);
    chk("midsync_se_cnt", se_cnt, 1);
    chk("midsync_fv_cnt", fv_cnt, 1);
    chk("midsync_ch_data", ch_data, 32'h55AAF00F);
    chk("midsync_locked", locked, 1'b1);

    // Reset at bit 20 of a frame
    clear_counts();
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    for (int i = 7; i >= 5; i--) send_bit(w01[i], 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("midrst_ch_data", ch_data, 32'h0);
    chk("midrst_fv", frame_valid, 1'b0);
    chk("midrst_se", sync_err, 1'b0);
    chk("midrst_locked", locked, 1'b0);
    chk("midrst_idx", ch_idx, 2'd0);
    for (int i = 0; i < 12; i++) send_bit(i[0], 1'b0);
    chk("midrst_no_fv", fv_cnt, 0);
    chk("midrst_still_zero", ch_data, 32'h0);
    chk("midrst_hunt", locked, 1'b0);

    chk("fv_se_exclusive", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
